fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the CPU datapath. It owns the program counter, issues sequential read requests to `insMem`, and buffers returned instructions, each tagged with its PC, in a small prefetch FIFO. It delivers instructions to decode over a valid/ready handshake. A branch/jump redirect from the datapath flushes the FIFO and restarts fetch at the new target.

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side
// valid/ready handshake and the datapath redirect.
interface fetch_unit_if;
    // Decode handshake: a transfer happens in any cycle where out_valid && out_ready
    // at the rising edge. out_valid never depends on out_ready, and once raised,
    // out_valid/out_instr/out_pc hold until that transfer or a redirect.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, sequential insMem requests, PC-tagged prefetch FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus,
    output logic [1:0]   dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic          redirect_take;
    logic          resp_live;
    logic          fifo_empty;
    logic          issue;
    logic          bypass;
    logic          handshake;
    logic          push;
    logic          pop;
    logic [AW+1:0] occupancy;
    logic [1:0]    unused_redirect_lsb;

    assign unused_redirect_lsb = bus.redirect_pc[1:0];

    // Response handling and issue decision.
    always_comb begin
        redirect_take = bus.redirect && (state_q != ST_BOOT);
        // A response is only usable in RUN; one landing in FLUSH belongs to a dead stream.
        resp_live     = inflight_q && (state_q == ST_RUN);
        fifo_empty    = (count_q == '0);
        occupancy     = {1'b0, count_q} + (AW+2)'(inflight_q);
        issue         = (state_q == ST_RUN) && (occupancy < (AW+2)'(DEPTH));
`ifdef FETCH_BYPASS_EN
        bypass        = fifo_empty && resp_live;
`else
        bypass        = 1'b0;
`endif
    end

    // Decode-side outputs: FIFO head, or the live response when bypassing.
    always_comb begin
        bus.out_valid = !fifo_empty || bypass;
        bus.out_instr = '0;
        bus.out_pc    = '0;
        if (!fifo_empty) begin
            bus.out_instr = mem_instr_q[rd_ptr_q];
            bus.out_pc    = mem_pc_q[rd_ptr_q];
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass) begin
            bus.out_instr = bus.imem_data;
            bus.out_pc    = req_pc_q;
        end
`endif
    end

    always_comb begin
        handshake = bus.out_valid && bus.out_ready;
        pop       = handshake && !fifo_empty;
        // A bypassed word taken by decode this cycle never occupies a slot.
        push      = resp_live && !redirect_take && !(bypass && bus.out_ready);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (redirect_take) state_d = ST_FLUSH;
            ST_FLUSH: state_d = redirect_take ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
        end
        if (redirect_take) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= BOOT_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: outputs are gated by count, which is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= req_pc_q;
            mem_instr_q[wr_ptr_q] <= bus.imem_data;
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic
// compared against an in-order PC stream model.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;

    fetch_unit_if bus ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // insMem model: data valid exactly one cycle after the request.
    initial begin : responder
        logic        r;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            r = bus.imem_req;
            a = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_data = r ? word_of(a) : $urandom();
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] req_q[$];
    logic [31:0] exp_req_q[$];
    int          req_cyc_q[$];
    logic [31:0] hs_pc_q[$];
    logic [31:0] hs_instr_q[$];
    int          hs_cyc_q[$];
    logic [31:0] exp_q[$];
    int          first_valid_cyc;
    int          stab_err = 0;
    int          flush_req_err = 0;
    logic [31:0] m_pc, m_addr, p_pc, p_instr;
    logic        p_valid, p_hs, p_redir;

    always @(negedge clk or negedge reset) begin : monitor
        logic hs, take;
        if (!reset) begin
            req_q.delete(); exp_req_q.delete(); req_cyc_q.delete();
            hs_pc_q.delete(); hs_instr_q.delete(); hs_cyc_q.delete(); exp_q.delete();
            first_valid_cyc = -1;
            m_pc = RPC; m_addr = RPC;
            p_valid = 1'b0; p_hs = 1'b0; p_redir = 1'b0;
            p_pc = '0; p_instr = '0;
        end else begin
            if (p_valid && !p_hs && !p_redir &&
                (bus.out_valid !== 1'b1 || bus.out_pc !== p_pc || bus.out_instr !== p_instr))
                stab_err++;
            if (p_redir && bus.imem_req === 1'b1) flush_req_err++;
            if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.imem_req === 1'b1) begin
                req_q.push_back(bus.imem_addr);
                exp_req_q.push_back(m_addr);
                req_cyc_q.push_back(cyc);
                m_addr = m_addr + 32'd4;
            end
            hs = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
            if (hs) begin
                hs_pc_q.push_back(bus.out_pc);
                hs_instr_q.push_back(bus.out_instr);
                hs_cyc_q.push_back(cyc);
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            take = (bus.redirect === 1'b1) && (cyc != 0);
            if (take) begin
                m_pc   = {bus.redirect_pc[31:2], 2'b00};
                m_addr = {bus.redirect_pc[31:2], 2'b00};
            end
            p_valid = (bus.out_valid === 1'b1);
            p_hs    = hs;
            p_redir = take;
            p_pc    = bus.out_pc;
            p_instr = bus.out_instr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 1000) begin
            tick();
            guard++;
        end
        total++;
        if (cyc < n) begin
            bad++;
            $display("FAIL run_to timeout: cyc=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic do_reset(input logic rdy);
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = rdy;
        tick();
        tick();
        @(posedge clk);
        #4;
        reset = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        tick();
        bus.redirect    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b1;
        bus.imem_data   = '0;
        tick();
        tick();
        total += 6;
        if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
        if (bus.imem_addr !== RPC) begin bad++; $display("FAIL reset_addr got %h exp %h", bus.imem_addr, RPC); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got %h exp 0", bus.out_instr); end
        if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h exp 0", bus.out_pc); end
        if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_stream();
        int gaps = 0;
        do_reset(1'b1);
        run_to(24);
        total += 3;
        if (first_valid_cyc != LAT) begin bad++; $display("FAIL stream_first_valid got %0d exp %0d", first_valid_cyc, LAT); end
        if (hs_pc_q.size() != 24 - LAT) begin bad++; $display("FAIL stream_count got %0d exp %0d", hs_pc_q.size(), 24 - LAT); end
        if (req_q.size() < 6) begin bad++; $display("FAIL stream_req_count got %0d exp >=6", req_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (req_q[i] !== RPC + 32'(4 * i)) begin bad++; $display("FAIL stream_addr[%0d] got %h exp %h", i, req_q[i], RPC + 32'(4 * i)); end
            end
        end
        for (int i = 0; i < hs_pc_q.size(); i++) begin
            total += 2;
            if (hs_pc_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_pc[%0d] got %h exp %h", i, hs_pc_q[i], exp_q[i]); end
            if (hs_instr_q[i] !== word_of(exp_q[i])) begin bad++; $display("FAIL stream_instr[%0d] got %h exp %h", i, hs_instr_q[i], word_of(exp_q[i])); end
            if (i > 0 && hs_cyc_q[i] != hs_cyc_q[i-1] + 1) gaps++;
        end
        total++;
        if (gaps != 0) begin bad++; $display("FAIL stream_gaps got %0d exp 0", gaps); end
    endtask

    task automatic test_backpressure();
        int gaps = 0;
        do_reset(1'b0);
        run_to(11);
        total += 4;
        if (req_q.size() != DEPTH) begin bad++; $display("FAIL bp_req_count got %0d exp %0d", req_q.size(), DEPTH); end
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                total++;
                if (req_q[i] !== RPC + 32'(4 * i)) begin bad++; $display("FAIL bp_addr[%0d] got %h exp %h", i, req_q[i], RPC + 32'(4 * i)); end
            end
        end
        if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_idle got %b exp 0", bus.imem_req); end
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got %b exp 1", bus.out_valid); end
        if (bus.out_pc !== RPC) begin bad++; $display("FAIL bp_head_pc got %h exp %h", bus.out_pc, RPC); end
        bus.out_ready = 1'b1;
        run_to(26);
        total += 3;
        if (hs_pc_q.size() != 15) begin bad++; $display("FAIL bp_drain_count got %0d exp 15", hs_pc_q.size()); end
        if (hs_cyc_q.size() == 0 || hs_cyc_q[0] != 11) begin bad++; $display("FAIL bp_first_hs_cyc got %0d exp 11", hs_cyc_q.size() ? hs_cyc_q[0] : -1); end
        if (req_q.size() <= DEPTH || req_q[DEPTH] !== RPC + 32'h10) begin bad++; $display("FAIL bp_resume got size %0d exp addr %h", req_q.size(), RPC + 32'h10); end
        for (int i = 0; i < hs_pc_q.size(); i++) begin
            total += 2;
            if (hs_pc_q[i] !== RPC + 32'(4 * i)) begin bad++; $display("FAIL bp_pc[%0d] got %h exp %h", i, hs_pc_q[i], RPC + 32'(4 * i)); end
            if (hs_instr_q[i] !== word_of(exp_q[i])) begin bad++; $display("FAIL bp_instr[%0d] got %h exp %h", i, hs_instr_q[i], word_of(exp_q[i])); end
            if (i > 0 && hs_cyc_q[i] != hs_cyc_q[i-1] + 1) gaps++;
        end
        total++;
        if (gaps != 0) begin bad++; $display("FAIL bp_gaps got %0d exp 0", gaps); end
    endtask

    task automatic test_redirect();
        int nreq;
        int fbase = flush_req_err;
        do_reset(1'b0);
        run_to(5);
        nreq = req_q.size();
        do_redirect(32'h0000_0203);
        bus.out_ready = 1'b1;
        total += 2;
        if (nreq != DEPTH) begin bad++; $display("FAIL redir_pre_reqs got %0d exp %0d", nreq, DEPTH); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_valid got %b exp 0", bus.out_valid); end
        run_to(16);
        total += 5;
        if (req_q.size() <= nreq || req_q[nreq] !== 32'h200) begin bad++; $display("FAIL redir_addr got size %0d exp addr 00000200", req_q.size()); end
        if (req_cyc_q.size() <= nreq || req_cyc_q[nreq] != 7) begin bad++; $display("FAIL redir_req_cyc got %0d exp 7", req_cyc_q.size() > nreq ? req_cyc_q[nreq] : -1); end
        if (hs_pc_q.size() == 0 || hs_pc_q[0] !== 32'h200) begin bad++; $display("FAIL redir_first_pc got %h exp 00000200", hs_pc_q.size() ? hs_pc_q[0] : 32'hX); end
        if (hs_cyc_q.size() == 0 || hs_cyc_q[0] != 5 + LAT + 1) begin bad++; $display("FAIL redir_first_cyc got %0d exp %0d", hs_cyc_q.size() ? hs_cyc_q[0] : -1, 5 + LAT + 1); end
        if (flush_req_err != fbase) begin bad++; $display("FAIL redir_flush_req got %0d exp 0", flush_req_err - fbase); end
        for (int i = 0; i < hs_pc_q.size(); i++) begin
            total += 2;
            if (hs_pc_q[i] !== exp_q[i]) begin bad++; $display("FAIL redir_pc[%0d] got %h exp %h", i, hs_pc_q[i], exp_q[i]); end
            if (hs_instr_q[i] !== word_of(exp_q[i])) begin bad++; $display("FAIL redir_instr[%0d] got %h exp %h", i, hs_instr_q[i], word_of(exp_q[i])); end
        end
    endtask

    task automatic test_back_to_back_redirect_hs();
        int k = 0;
        do_reset(1'b1);
        run_to(6);
        do_redirect(32'h0000_0400);
        run_to(16);
        while (k < hs_cyc_q.size() && hs_cyc_q[k] <= 6) k++;
        total += 4;
        if (k != 6 - LAT + 1) begin bad++; $display("FAIL hsredir_pre_count got %0d exp %0d", k, 6 - LAT + 1); end
        if (k == 0 || hs_pc_q[k-1] !== RPC + 32'(4 * (6 - LAT))) begin bad++; $display("FAIL hsredir_last_old got %h exp %h", k ? hs_pc_q[k-1] : 32'hX, RPC + 32'(4 * (6 - LAT))); end
        if (k >= hs_pc_q.size() || hs_pc_q[k] !== 32'h400) begin bad++; $display("FAIL hsredir_first_new got %h exp 00000400", k < hs_pc_q.size() ? hs_pc_q[k] : 32'hX); end
        if (k >= hs_cyc_q.size() || hs_cyc_q[k] != 6 + LAT + 1) begin bad++; $display("FAIL hsredir_new_cyc got %0d exp %0d", k < hs_cyc_q.size() ? hs_cyc_q[k] : -1, 6 + LAT + 1); end
        for (int i = 0; i < hs_pc_q.size(); i++) begin
            total += 2;
            if (hs_pc_q[i] !== exp_q[i]) begin bad++; $display("FAIL hsredir_pc[%0d] got %h exp %h", i, hs_pc_q[i], exp_q[i]); end
            if (hs_instr_q[i] !== word_of(exp_q[i])) begin bad++; $display("FAIL hsredir_instr[%0d] got %h exp %h", i, hs_instr_q[i], word_of(exp_q[i])); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_exp [3];
        int j = 0;
        int h = 0;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        do_reset(1'b1);
        run_to(4);
        do_redirect(32'hFFFF_FFF8);
        run_to(14);
        while (j < req_cyc_q.size() && req_cyc_q[j] <= 4) j++;
        while (h < hs_cyc_q.size() && hs_cyc_q[h] <= 4) h++;
        for (int i = 0; i < 3; i++) begin
            total += 2;
            if (j + i >= req_q.size() || req_q[j+i] !== wrap_exp[i]) begin bad++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, (j + i < req_q.size()) ? req_q[j+i] : 32'hX, wrap_exp[i]); end
            if (h + i >= hs_pc_q.size() || hs_pc_q[h+i] !== wrap_exp[i]) begin bad++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, (h + i < hs_pc_q.size()) ? hs_pc_q[h+i] : 32'hX, wrap_exp[i]); end
        end
        for (int i = 0; i < hs_pc_q.size(); i++) begin
            total++;
            if (hs_instr_q[i] !== word_of(exp_q[i])) begin bad++; $display("FAIL wrap_instr[%0d] got %h exp %h", i, hs_instr_q[i], word_of(exp_q[i])); end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        run_to(8);
        @(posedge clk);
        #3;
        total += 2;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got %b exp 1", bus.out_valid); end
        if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL areset_pre_req got %b exp 1", bus.imem_req); end
        reset = 1'b0;
        #1;
        total += 3;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got %b exp 0", bus.out_valid); end
        if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL areset_req got %b exp 0", bus.imem_req); end
        if (bus.imem_addr !== RPC) begin bad++; $display("FAIL areset_addr got %h exp %h", bus.imem_addr, RPC); end
        tick();
        @(posedge clk);
        #4;
        reset = 1'b1;
        run_to(12);
        total += 4;
        if (req_q.size() == 0 || req_q[0] !== RPC) begin bad++; $display("FAIL areset_restart_addr got %h exp %h", req_q.size() ? req_q[0] : 32'hX, RPC); end
        if (req_cyc_q.size() == 0 || req_cyc_q[0] != 1) begin bad++; $display("FAIL areset_restart_cyc got %0d exp 1", req_cyc_q.size() ? req_cyc_q[0] : -1); end
        if (hs_pc_q.size() == 0 || hs_pc_q[0] !== RPC) begin bad++; $display("FAIL areset_first_pc got %h exp %h", hs_pc_q.size() ? hs_pc_q[0] : 32'hX, RPC); end
        if (first_valid_cyc != LAT) begin bad++; $display("FAIL areset_first_valid got %0d exp %0d", first_valid_cyc, LAT); end
    endtask

    task automatic test_random();
        int sbase = stab_err;
        int fbase = flush_req_err;
        do_reset(1'b1);
        repeat (400) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                bus.redirect = 1'b1;
                case ($urandom_range(0, 2))
                    0:       bus.redirect_pc = $urandom();
                    1:       bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    default: bus.redirect_pc = 32'h0000_1000 + 32'($urandom_range(0, 255));
                endcase
            end else begin
                bus.redirect = 1'b0;
            end
            tick();
        end
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        total += 4;
        if (hs_pc_q.size() < 50) begin bad++; $display("FAIL rand_hs_count got %0d exp >=50", hs_pc_q.size()); end
        if (req_q.size() < 50) begin bad++; $display("FAIL rand_req_count got %0d exp >=50", req_q.size()); end
        if (stab_err != sbase) begin bad++; $display("FAIL rand_stability got %0d exp 0", stab_err - sbase); end
        if (flush_req_err != fbase) begin bad++; $display("FAIL rand_flush_req got %0d exp 0", flush_req_err - fbase); end
        for (int i = 0; i < req_q.size(); i++) begin
            total++;
            if (req_q[i] !== exp_req_q[i]) begin bad++; $display("FAIL rand_addr[%0d] got %h exp %h", i, req_q[i], exp_req_q[i]); end
        end
        for (int i = 0; i < hs_pc_q.size(); i++) begin
            total += 2;
            if (hs_pc_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_pc[%0d] got %h exp %h", i, hs_pc_q[i], exp_q[i]); end
            if (hs_instr_q[i] !== word_of(exp_q[i])) begin bad++; $display("FAIL rand_instr[%0d] got %h exp %h", i, hs_instr_q[i], word_of(exp_q[i])); end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back_redirect_hs();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
